// File: rtl/secsys_zone_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : secsys_zone_ctrl
// Purpose  : Multi-zone alarm controller with exit/entry delays, siren timeout,
//            qualified WiFi commands. Optional SECSYS_ZONE_LATCH_EN trip capture.
// Revision : 1.0 - initial release
// ============================================================================
module secsys_zone_ctrl #(
    parameter int N_ZONES   = 4,
    parameter int EXIT_DLY  = 50000000,
    parameter int ENTRY_DLY = 50000000,
    parameter int SIREN_TO  = 500000000,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic [N_ZONES-1:0] zone_in,
    input  logic [N_ZONES-1:0] zone_en,
    input  logic [N_ZONES-1:0] zone_hub,
    input  logic [3:0]         in_wifi,
    input  logic               in_wifi_valid,
    output logic               out_wifi,
    output logic               siren,
    output logic               lock,
    output logic               inactive_n,
    output logic               active_n,
    output logic               alarm_n,
    output logic               emergency_n,
    output logic [2:0]         message,
    output logic [N_ZONES-1:0] trig_zone
);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'b000,
        S_EXIT      = 3'b001,
        S_ARMED     = 3'b010,
        S_ENTRY     = 3'b011,
        S_ALARM     = 3'b100,
        S_EMERGENCY = 3'b101
    } state_t;

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               silenced, silenced_nx;
    logic [N_ZONES-1:0] zone_s1, zone_s2;
    logic               trip_hub, trip_per;
    logic               cmd_disarm, cmd_rearm, cmd_escalate, cmd_silence;
    logic               out_wifi_d, siren_d, lock_d;
    logic               inactive_n_d, active_n_d, alarm_n_d, emergency_n_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zone_s1 <= '0;
            zone_s2 <= '0;
        end else begin
            zone_s1 <= zone_in;
            zone_s2 <= zone_s1;
        end
    end

    assign trip_hub = |(zone_s2 & zone_en & zone_hub);
    assign trip_per = |(zone_s2 & zone_en & ~zone_hub);

    assign cmd_disarm   = in_wifi_valid && (in_wifi == 4'b1010);
    assign cmd_rearm    = in_wifi_valid && (in_wifi == 4'b1011);
    assign cmd_escalate = in_wifi_valid && (in_wifi == 4'b1100);
    assign cmd_silence  = in_wifi_valid && (in_wifi == 4'b1101);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_DISARMED;
            cnt      <= '0;
            silenced <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            silenced <= silenced_nx;
        end
    end

    // Commands are tested first in every branch so they outrank zone trips,
    // and zone trips outrank counter expiry.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        silenced_nx = silenced;
        case (state)
            S_DISARMED: begin
                if (arm) begin
                    state_nx = S_EXIT;
                    cnt_nx   = EXIT_LD;
                end
            end
            S_EXIT: begin
                if (cmd_disarm) begin
                    state_nx = S_DISARMED;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx = S_ARMED;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_ARMED: begin
                if (cmd_disarm) begin
                    state_nx = S_DISARMED;
                end else if (trip_hub) begin
                    state_nx = S_EMERGENCY;
                end else if (trip_per) begin
                    state_nx = S_ENTRY;
                    cnt_nx   = ENTRY_LD;
                end
            end
            S_ENTRY: begin
                if (cmd_disarm) begin
                    state_nx = S_DISARMED;
                    cnt_nx   = '0;
                end else if (trip_hub) begin
                    state_nx = S_EMERGENCY;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx    = S_ALARM;
                    cnt_nx      = SIREN_LD;
                    silenced_nx = 1'b0;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            S_ALARM: begin
                if (cmd_disarm) begin
                    state_nx = S_DISARMED;
                    cnt_nx   = '0;
                end else if (cmd_rearm) begin
                    state_nx = S_ARMED;
                    cnt_nx   = '0;
                end else if (cmd_escalate || trip_hub) begin
                    state_nx = S_EMERGENCY;
                    cnt_nx   = '0;
                end else begin
                    if (cmd_silence || (cnt == '0))
                        silenced_nx = 1'b1;
                    if (cnt != '0)
                        cnt_nx = cnt - CNT_ONE;
                end
            end
            S_EMERGENCY: begin
                if (cmd_disarm) begin
                    state_nx = S_DISARMED;
                end else if (cmd_rearm) begin
                    state_nx = S_ARMED;
                end
            end
            default: begin
                state_nx = S_DISARMED;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        out_wifi_d    = 1'b0;
        siren_d       = 1'b0;
        lock_d        = 1'b0;
        inactive_n_d  = 1'b1;
        active_n_d    = 1'b1;
        alarm_n_d     = 1'b1;
        emergency_n_d = 1'b1;
        case (state)
            S_DISARMED: inactive_n_d = 1'b0;
            S_EXIT, S_ARMED: active_n_d = 1'b0;
            S_ENTRY: begin
                active_n_d = 1'b0;
                out_wifi_d = 1'b1;
            end
            S_ALARM: begin
                alarm_n_d  = 1'b0;
                out_wifi_d = 1'b1;
                siren_d    = ~silenced;
            end
            S_EMERGENCY: begin
                emergency_n_d = 1'b0;
                out_wifi_d    = 1'b1;
                siren_d       = 1'b1;
                lock_d        = 1'b1;
            end
            default: inactive_n_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wifi    <= 1'b0;
            siren       <= 1'b0;
            lock        <= 1'b0;
            inactive_n  <= 1'b1;
            active_n    <= 1'b1;
            alarm_n     <= 1'b1;
            emergency_n <= 1'b1;
            message     <= 3'b000;
        end else begin
            out_wifi    <= out_wifi_d;
            siren       <= siren_d;
            lock        <= lock_d;
            inactive_n  <= inactive_n_d;
            active_n    <= active_n_d;
            alarm_n     <= alarm_n_d;
            emergency_n <= emergency_n_d;
            message     <= state;
        end
    end

`ifdef SECSYS_ZONE_LATCH_EN
    logic [N_ZONES-1:0] trig_q;

    // Clearing on entry to DISARMED/EXIT wins over a capture in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q <= '0;
        end else if ((state_nx != state) &&
                     ((state_nx == S_DISARMED) || (state_nx == S_EXIT))) begin
            trig_q <= '0;
        end else if ((state == S_ENTRY) || (state == S_ALARM) ||
                     (state == S_EMERGENCY) ||
                     ((state == S_ARMED) && (state_nx != S_ARMED))) begin
            trig_q <= trig_q | (zone_s2 & zone_en);
        end
    end

    assign trig_zone = trig_q;
`else
    assign trig_zone = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_secsys_zone_ctrl.sv
`default_nettype none
// Directed self-checking bench for secsys_zone_ctrl
// (N_ZONES=4, EXIT_DLY=4, ENTRY_DLY=3, SIREN_TO=8).
module tb_secsys_zone_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arm = 1'b0;
    logic [3:0] zone_in = 4'b0000;
    logic [3:0] zone_en = 4'b1111;
    logic [3:0] zone_hub = 4'b0000;
    logic [3:0] in_wifi = 4'b0000;
    logic       in_wifi_valid = 1'b0;
    logic       out_wifi, siren, lock;
    logic       inactive_n, active_n, alarm_n, emergency_n;
    logic [2:0] message;
    logic [3:0] trig_zone;

    int checks = 0;
    int fails  = 0;

    secsys_zone_ctrl #(
        .N_ZONES   (4),
        .EXIT_DLY  (4),
        .ENTRY_DLY (3),
        .SIREN_TO  (8),
        .CNT_W     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .zone_in       (zone_in),
        .zone_en       (zone_en),
        .zone_hub      (zone_hub),
        .in_wifi       (in_wifi),
        .in_wifi_valid (in_wifi_valid),
        .out_wifi      (out_wifi),
        .siren         (siren),
        .lock          (lock),
        .inactive_n    (inactive_n),
        .active_n      (active_n),
        .alarm_n       (alarm_n),
        .emergency_n   (emergency_n),
        .message       (message),
        .trig_zone     (trig_zone)
    );

    always #5 clk = ~clk;

    // {inactive_n, active_n, alarm_n, emergency_n, out_wifi, siren, lock, message}
    wire [9:0] obs = {inactive_n, active_n, alarm_n, emergency_n,
                      out_wifi, siren, lock, message};

    localparam logic [9:0] O_RST       = 10'b1111_000_000;
    localparam logic [9:0] O_DIS       = 10'b0111_000_000;
    localparam logic [9:0] O_EXIT      = 10'b1011_000_001;
    localparam logic [9:0] O_ARMED     = 10'b1011_000_010;
    localparam logic [9:0] O_ENTRY     = 10'b1011_100_011;
    localparam logic [9:0] O_ALARM_ON  = 10'b1101_110_100;
    localparam logic [9:0] O_ALARM_OFF = 10'b1101_100_100;
    localparam logic [9:0] O_EMERG     = 10'b1110_111_101;

`ifdef SECSYS_ZONE_LATCH_EN
    localparam logic [3:0] TRIG_EXP = 4'b0100;
`else
    localparam logic [3:0] TRIG_EXP = 4'b0000;
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [3:0] code);
        in_wifi       = code;
        in_wifi_valid = 1'b1;
        tick(1);
        in_wifi_valid = 1'b0;
        in_wifi       = 4'b0000;
    endtask

    task automatic go_armed();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        tick(5);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        checks++;
        if (obs !== O_RST) begin
            $display("FAIL reset_state: got %b, expected %b", obs, O_RST);
            fails++;
        end
        checks++;
        if (trig_zone !== 4'b0000) begin
            $display("FAIL reset_trig: got %b, expected %b", trig_zone, 4'b0000);
            fails++;
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (obs !== O_DIS) begin
            $display("FAIL post_reset_decode: got %b, expected %b", obs, O_DIS);
            fails++;
        end
        go_armed();
        zone_hub = 4'b0001;
        zone_in  = 4'b0001;
        tick(4);
        checks++;
        if (obs !== O_EMERG) begin
            $display("FAIL hub_emergency: got %b, expected %b", obs, O_EMERG);
            fails++;
        end
        zone_in  = 4'b0000;
        zone_hub = 4'b0000;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== O_RST) begin
            $display("FAIL reset_mid_emergency: got %b, expected %b", obs, O_RST);
            fails++;
        end
        tick(2);
        reset = 1'b1;
        tick(1);
        checks++;
        if (obs !== O_DIS) begin
            $display("FAIL release_decode: got %b, expected %b", obs, O_DIS);
            fails++;
        end
    endtask

    task automatic test_exit();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        checks++;
        if (obs !== O_DIS) begin
            $display("FAIL exit_out_latency: got %b, expected %b", obs, O_DIS);
            fails++;
        end
        zone_in = 4'b0001;
        tick(1);
        zone_in = 4'b0000;
        checks++;
        if (obs !== O_EXIT) begin
            $display("FAIL exit_cycle1: got %b, expected %b", obs, O_EXIT);
            fails++;
        end
        for (int i = 2; i <= 4; i++) begin
            tick(1);
            checks++;
            if (obs !== O_EXIT) begin
                $display("FAIL exit_cycle%0d: got %b, expected %b", i, obs, O_EXIT);
                fails++;
            end
        end
        tick(1);
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL exit_to_armed: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
        tick(3);
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL exit_zone_ignored: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
    endtask

    task automatic test_entry_alarm();
        zone_in = 4'b0010;
        tick(2);
        zone_in = 4'b0000;
        tick(1);
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL zone_latency: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            checks++;
            if (obs !== O_ENTRY) begin
                $display("FAIL entry_cycle%0d: got %b, expected %b", i, obs, O_ENTRY);
                fails++;
            end
        end
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            checks++;
            if (obs !== O_ALARM_ON) begin
                $display("FAIL siren_cycle%0d: got %b, expected %b", i, obs, O_ALARM_ON);
                fails++;
            end
        end
        tick(1);
        checks++;
        if (obs !== O_ALARM_OFF) begin
            $display("FAIL siren_timeout: got %b, expected %b", obs, O_ALARM_OFF);
            fails++;
        end
        tick(3);
        checks++;
        if (obs !== O_ALARM_OFF) begin
            $display("FAIL alarm_hold: got %b, expected %b", obs, O_ALARM_OFF);
            fails++;
        end
    endtask

    task automatic test_commands();
        cmd(4'b1100);
        checks++;
        if (obs !== O_ALARM_OFF) begin
            $display("FAIL cmd_out_latency: got %b, expected %b", obs, O_ALARM_OFF);
            fails++;
        end
        tick(1);
        checks++;
        if (obs !== O_EMERG) begin
            $display("FAIL escalate: got %b, expected %b", obs, O_EMERG);
            fails++;
        end
        cmd(4'b1101);
        tick(1);
        checks++;
        if (obs !== O_EMERG) begin
            $display("FAIL silence_in_emergency: got %b, expected %b", obs, O_EMERG);
            fails++;
        end
        cmd(4'b1011);
        tick(1);
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL rearm_from_emergency: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
        in_wifi = 4'b1010;
        tick(2);
        in_wifi = 4'b0000;
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL unqualified_cmd: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
    endtask

    task automatic test_silence();
        zone_in = 4'b0010;
        tick(2);
        zone_in = 4'b0000;
        tick(5);
        checks++;
        if (obs !== O_ALARM_ON) begin
            $display("FAIL alarm_reentry: got %b, expected %b", obs, O_ALARM_ON);
            fails++;
        end
        tick(2);
        cmd(4'b1101);
        checks++;
        if (obs !== O_ALARM_ON) begin
            $display("FAIL silence_latency: got %b, expected %b", obs, O_ALARM_ON);
            fails++;
        end
        tick(1);
        checks++;
        if (obs !== O_ALARM_OFF) begin
            $display("FAIL silence_cmd: got %b, expected %b", obs, O_ALARM_OFF);
            fails++;
        end
        cmd(4'b1011);
        tick(1);
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL rearm_from_alarm: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        zone_hub = 4'b1000;
        zone_in  = 4'b0010;
        tick(1);
        zone_in  = 4'b1010;
        tick(2);
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL prio_pre_entry: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
        cmd(4'b1010);
        zone_in  = 4'b0000;
        checks++;
        if (obs !== O_ENTRY) begin
            $display("FAIL prio_entry: got %b, expected %b", obs, O_ENTRY);
            fails++;
        end
        tick(1);
        zone_hub = 4'b0000;
        checks++;
        if (obs !== O_DIS) begin
            $display("FAIL disarm_beats_hub: got %b, expected %b", obs, O_DIS);
            fails++;
        end
        tick(3);
        checks++;
        if (obs !== O_DIS) begin
            $display("FAIL disarmed_hold: got %b, expected %b", obs, O_DIS);
            fails++;
        end
    endtask

    task automatic test_zone_enable();
        go_armed();
        zone_en = 4'b1110;
        zone_in = 4'b0001;
        tick(4);
        checks++;
        if (obs !== O_ARMED) begin
            $display("FAIL disabled_zone: got %b, expected %b", obs, O_ARMED);
            fails++;
        end
        zone_in = 4'b0101;
        tick(3);
        checks++;
        if (trig_zone !== TRIG_EXP) begin
            $display("FAIL trig_capture: got %b, expected %b", trig_zone, TRIG_EXP);
            fails++;
        end
        zone_in = 4'b0000;
        tick(1);
        checks++;
        if (obs !== O_ENTRY) begin
            $display("FAIL enabled_zone_entry: got %b, expected %b", obs, O_ENTRY);
            fails++;
        end
        checks++;
        if (trig_zone !== TRIG_EXP) begin
            $display("FAIL trig_hold: got %b, expected %b", trig_zone, TRIG_EXP);
            fails++;
        end
        cmd(4'b1010);
        checks++;
        if (trig_zone !== 4'b0000) begin
            $display("FAIL trig_clear: got %b, expected %b", trig_zone, 4'b0000);
            fails++;
        end
        tick(1);
        zone_en = 4'b1111;
        checks++;
        if (obs !== O_DIS) begin
            $display("FAIL disarm_from_entry: got %b, expected %b", obs, O_DIS);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_exit();
        test_entry_alarm();
        test_commands();
        test_silence();
        test_back_to_back();
        test_zone_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
